// File: rtl/adsr_vca_if.sv
// Control/audio bundle for the ADSR envelope + VCA block.
// The master drives the sample strobe, gate, step settings and audio in; the slave returns the shaped audio.
interface adsr_vca_if;
  logic               Enable;
  logic               Gate;
  logic        [15:0] attack_step;
  logic        [15:0] decay_step;
  logic        [15:0] sustain_level;
  logic        [15:0] release_step;
  logic signed [15:0] x;
  logic signed [15:0] y;
  logic        [15:0] env;
  logic               active;

  modport master (
    output Enable, Gate, attack_step, decay_step, sustain_level, release_step, x,
    input  y, env, active
  );

  modport slave (
    input  Enable, Gate, attack_step, decay_step, sustain_level, release_step, x,
    output y, env, active
  );
endinterface

// File: rtl/adsr_vca.sv
// ADSR envelope generator driving a VCA.
// Everything advances one step per Enable strobe. y is built from the envelope value held before the current step.
module adsr_vca (
  input  logic      Clk,
  input  logic      Reset,
  adsr_vca_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;

  state_t state;

  // 17-bit arithmetic so the clamps below see overflow and underflow instead of a wrapped value
  logic        [16:0] atk_sum;
  logic signed [16:0] dec_diff;
  logic signed [32:0] prod;
  logic signed [15:0] y_next;

  assign atk_sum  = {1'b0, bus.env} + {1'b0, bus.attack_step};
  assign dec_diff = $signed({1'b0, bus.env}) - $signed({1'b0, bus.decay_step});
  assign prod     = bus.x * $signed({1'b0, bus.env});
  assign y_next   = 16'(prod >>> 16);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      bus.env    <= '0;
      bus.y      <= '0;
      bus.active <= 1'b0;
    end else if (bus.Enable) begin
      bus.y <= y_next;
      case (state)
        IDLE: begin
          if (bus.Gate) begin
            state      <= ATTACK;
            bus.active <= 1'b1;
          end else begin
            bus.env <= '0;
          end
        end
        ATTACK: begin
          if (!bus.Gate) begin
            state <= RELEASE;
          end else if (bus.attack_step == '0 || atk_sum >= 17'd65535) begin
            bus.env <= 16'hFFFF;
            state   <= DECAY;
          end else begin
            bus.env <= atk_sum[15:0];
          end
        end
        DECAY: begin
          if (!bus.Gate) begin
            state <= RELEASE;
          end else if (bus.decay_step == '0 ||
                       dec_diff <= $signed({1'b0, bus.sustain_level})) begin
            bus.env <= bus.sustain_level;
            state   <= SUSTAIN;
          end else begin
            bus.env <= dec_diff[15:0];
          end
        end
        SUSTAIN: begin
          if (!bus.Gate) state   <= RELEASE;
          else           bus.env <= bus.sustain_level;
        end
        RELEASE: begin
          // retrigger keeps the current level so the attack resumes without a click
          if (bus.Gate) begin
            state <= ATTACK;
          end else if (bus.release_step == '0 || bus.env <= bus.release_step) begin
            bus.env    <= '0;
            state      <= IDLE;
            bus.active <= 1'b0;
          end else begin
            bus.env <= bus.env - bus.release_step;
          end
        end
        default: begin
          state      <= IDLE;
          bus.env    <= '0;
          bus.active <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_adsr_vca.sv
// Directed bench for adsr_vca: envelope segments, VCA arithmetic, zero steps, retrigger, hold and async reset.
module tb_adsr_vca;
  logic Clk;
  logic Reset;
  int   errors = 0;
  int   checks = 0;

  adsr_vca_if bus ();
  adsr_vca dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [15:0] exp_ad  [0:9] = '{16'd0, 16'd16384, 16'd32768, 16'd49152, 16'd65535,
                                 16'd57343, 16'd49151, 16'd40959, 16'd32768, 16'd32768};
  logic [15:0] exp_rel [0:4] = '{16'd32768, 16'd22768, 16'd12768, 16'd2768, 16'd0};

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, obs, obs, exp, exp);
    end
  endtask

  initial begin
    Reset             = 1'b0;
    bus.Enable        = 1'b0;
    bus.Gate          = 1'b0;
    bus.attack_step   = 16'd16384;
    bus.decay_step    = 16'd8192;
    bus.sustain_level = 16'd32768;
    bus.release_step  = 16'd10000;
    bus.x             = '0;
    tick();
    tick();
    chk("rst_env", bus.env, 16'd0);
    chk("rst_y", bus.y, 16'd0);
    chk("rst_active", {15'd0, bus.active}, 16'd1 - 16'd1);
    Reset = 1'b1;

    // attack / decay into sustain; the last entry confirms sustain holds the level
    bus.Enable = 1'b1;
    bus.Gate   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("ad_env[%0d]", i), bus.env, exp_ad[i]);
      if (i == 0) chk("ad_active", {15'd0, bus.active}, 16'd1);
    end

    // release to idle
    bus.Gate = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rel_env[%0d]", i), bus.env, exp_rel[i]);
      if (i == 3) chk("rel_active_hi", {15'd0, bus.active}, 16'd1);
      if (i == 4) chk("rel_active_lo", {15'd0, bus.active}, 16'd0);
    end

    // VCA math: sustain_level=65535 passes straight through decay and parks env at full scale
    bus.attack_step   = 16'd0;
    bus.decay_step    = 16'd0;
    bus.sustain_level = 16'd65535;
    bus.Gate          = 1'b1;
    tick(); chk("vca_e1", bus.env, 16'd0);
    tick(); chk("vca_e2", bus.env, 16'd65535);
    tick(); chk("vca_e3", bus.env, 16'd65535);
    bus.x = -16'sd32768;
    tick(); chk("vca_y_neg_full", bus.y, 16'h8000);
    bus.x             = 16'sd32767;
    bus.sustain_level = 16'd32768;
    tick(); chk("vca_y_pos_full", bus.y, 16'h7FFE);
    chk("vca_env_half", bus.env, 16'd32768);
    bus.x = -16'sd1;
    tick(); chk("vca_y_floor", bus.y, 16'hFFFF);
    bus.x = '0;

    // zero steps: release jumps straight to idle
    bus.Gate         = 1'b0;
    bus.release_step = 16'd0;
    tick(); chk("z_rel_enter", bus.env, 16'd32768);
    tick(); chk("z_rel_done", bus.env, 16'd0);
    chk("z_rel_active", {15'd0, bus.active}, 16'd0);
    bus.sustain_level = 16'd1000;
    bus.Gate          = 1'b1;
    tick(); chk("z_e1", bus.env, 16'd0);
    tick(); chk("z_e2", bus.env, 16'd65535);
    tick(); chk("z_e3", bus.env, 16'd1000);
    bus.Gate = 1'b0;
    tick(); chk("z_rel1", bus.env, 16'd1000);
    tick(); chk("z_rel2", bus.env, 16'd0);

    // retrigger from release
    bus.attack_step  = 16'd10000;
    bus.release_step = 16'd5000;
    bus.Gate         = 1'b1;
    tick(); chk("rt_e1", bus.env, 16'd0);
    tick(); chk("rt_e2", bus.env, 16'd10000);
    tick(); chk("rt_e3", bus.env, 16'd20000);
    bus.Gate = 1'b0;
    tick(); chk("rt_rel1", bus.env, 16'd20000);
    tick(); chk("rt_rel2", bus.env, 16'd15000);
    bus.Gate = 1'b1;
    tick(); chk("rt_att", bus.env, 16'd15000);
    bus.x = 16'sd16384;
    tick(); chk("rt_resume", bus.env, 16'd25000);
    chk("rt_y", bus.y, 16'd3750);

    // Enable low: nothing moves even as inputs change
    bus.Enable = 1'b0;
    bus.Gate   = 1'b0;
    bus.x      = -16'sd5;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("hold_env[%0d]", i), bus.env, 16'd25000);
      chk($sformatf("hold_y[%0d]", i), bus.y, 16'd3750);
      chk($sformatf("hold_act[%0d]", i), {15'd0, bus.active}, 16'd1);
    end

    // climb to full scale, decay to 40000, then async reset mid-cycle
    bus.Enable = 1'b1;
    bus.Gate   = 1'b1;
    bus.x      = 16'sd16384;
    tick(); chk("up1", bus.env, 16'd35000);
    tick(); chk("up2", bus.env, 16'd45000);
    tick(); chk("up3", bus.env, 16'd55000);
    tick(); chk("up4", bus.env, 16'd65000);
    tick(); chk("up5", bus.env, 16'd65535);
    bus.decay_step    = 16'd25535;
    bus.sustain_level = 16'd0;
    tick(); chk("dec_env", bus.env, 16'd40000);
    chk("dec_y", bus.y, 16'h3FFF);
    #3 Reset = 1'b0;
    #1;
    chk("arst_env", bus.env, 16'd0);
    chk("arst_y", bus.y, 16'd0);
    chk("arst_active", {15'd0, bus.active}, 16'd0);
    tick();
    tick();
    Reset = 1'b1;
    tick(); chk("post_rst_env", bus.env, 16'd0);
    chk("post_rst_active", {15'd0, bus.active}, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adsr_vca.md
ADSR_VCA -- requirements
Module: adsr_vca

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 Clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 Enable  input  1  sample strobe; one Clk cycle per audio sample.
REQ-005 Gate  input  1  note-on level; 1 = key held, 0 = key released.
REQ-006 attack_step  input  16  unsigned envelope increment per sample in ATTACK.
REQ-007 decay_step  input  16  unsigned envelope decrement per sample in DECAY.
REQ-008 sustain_level  input  16  unsigned sustain envelope level.
REQ-009 release_step  input  16  unsigned envelope decrement per sample in RELEASE.
REQ-010 x  input  16  signed audio sample; this is the biquad filter output, connected directly.
REQ-011 y  output  16  signed amplitude-shaped audio sample.
REQ-012 env  output  16  unsigned current envelope level (0 = silent, 65535 = full scale).
REQ-013 active  output  1  1 when the state is not IDLE.

Function
REQ-014 State, env and y SHALL change only on rising Clk edges where Enable=1; with Enable=0 all outputs SHALL hold.
REQ-015 States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
REQ-016 Gate is level-sensitive and sampled only when Enable=1.
REQ-017 IDLE or RELEASE with Gate=1 SHALL go to ATTACK; env is unchanged on that cycle, so a retrigger continues from the current level.
REQ-018 ATTACK, DECAY or SUSTAIN with Gate=0 SHALL go to RELEASE; env is unchanged on that cycle; this takes priority over the step rules below.
REQ-019 ATTACK with Gate=1: if attack_step=0 or env+attack_step >= 65535 (17-bit sum), env SHALL be set to 65535 and the state SHALL go to DECAY; otherwise env SHALL become env+attack_step.
REQ-020 DECAY with Gate=1: if decay_step=0 or env-decay_step <= sustain_level (signed 17-bit compare), env SHALL be set to sustain_level and the state SHALL go to SUSTAIN; otherwise env SHALL become env-decay_step.
REQ-021 SUSTAIN with Gate=1: env SHALL be set to sustain_level every Enable cycle, so live changes to sustain_level are tracked.
REQ-022 RELEASE with Gate=0: if release_step=0 or env <= release_step, env SHALL be set to 0 and the state SHALL go to IDLE; otherwise env SHALL become env-release_step.
REQ-023 IDLE with Gate=0: env SHALL be held at 0.
REQ-024 Zero step values SHALL mean an instantaneous jump to the segment target, never a stall.
REQ-025 On each Enable cycle, y SHALL be loaded with bits [31:16] of the signed product x * {1'b0, env}, where env is the registered value before that cycle's update.
REQ-026 The product SHALL be 33 bits wide with arithmetic truncation (floor); no rounding and no saturation.
REQ-027 Latency: y reflects the x presented on an Enable cycle and is visible on the following Clk cycle.
REQ-028 sustain_level > 65535 is impossible by width; sustain_level=65535 SHALL pass through DECAY in one Enable cycle.
REQ-029 env SHALL never wrap: all sums and differences are computed in 17 bits and clamped as specified above.

Reset
REQ-030 While Reset=0 (asynchronous, regardless of Clk or Enable), the state SHALL be IDLE, env SHALL be 0, y SHALL be 0 and active SHALL be 0.
REQ-031 Reset asserted mid-note SHALL abort the envelope immediately, with no RELEASE phase.
REQ-032 After Reset deasserts, the first Enable cycle with Gate=1 SHALL enter ATTACK.

Verification
REQ-033 Attack/decay: attack_step=16384, decay_step=8192, sustain_level=32768, Gate=1, Enable every cycle.
  Required env on successive Enables: 0 (enter ATTACK), 16384, 32768, 49152, 65535 (enter DECAY), 57343, 49151, 40959, 32768 (enter SUSTAIN).
REQ-034 Release: from SUSTAIN at 32768, Gate=0, release_step=10000.
  Required env: 32768 (enter RELEASE), 22768, 12768, 2768, 0 (enter IDLE); active goes 0 on the same edge env reaches 0.
REQ-035 VCA math, with env forced to 65535 then 32768:
  x=-32768 -> y=-32768; x=32767 -> y=32766; x=-1 with env=32768 -> y=-1.
REQ-036 Zero steps: attack_step=0, decay_step=0, release_step=0, sustain_level=1000.
  Gate=1 -> env 65535 on the 2nd Enable, 1000 on the 3rd; Gate=0 -> env 0 one Enable after entering RELEASE.
REQ-037 Retrigger and hold:
  Gate 1->0 during ATTACK at env=20000, then back to 1 two Enables later with release_step=5000 -> env 20000, 15000, then ATTACK resumes from 15000.
  Enable held low for 10 cycles -> outputs unchanged.
REQ-038 Async reset: Reset pulsed low mid-cycle during DECAY at env=40000 -> env=0, y=0, active=0 immediately, without a Clk edge.
